mux_4to1_rr_arbiter: RTL and testbench

//   Round-robin arbiter sharing one 4:1 mux among four requesters.

---
 rtl/mux_4to1_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_mux_4to1_rr_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter driving the select/enable of a shared 4:1 mux.
// Hold limit forces rotation when others are waiting.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - async active-low reset
//   req    - [3:0] request per source
//   grant  - [3:0] registered one-hot grant, 0 when idle
//   sel    - [1:0] mux select, index of owner, held when idle
//   en     - mux enable, 1 iff grant != 0
//   busy   - 1 while a grant is active
module mux_4to1_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       en,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HOLD);

  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;

  logic             take;
  logic [1:0]       nxt;

  // First set bit scanning p, p+1, ... (mod 4).
  // Walk offsets high to low so the nearest hit wins.
  function automatic logic [1:0] pick(
    input logic [1:0] p,
    input logic [3:0] r
  );
    logic [1:0] idx;
    pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    take    = 1'b0;
    nxt     = sel_q;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          take = 1'b1;
          nxt  = pick(last_q + 2'd1, req);
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          if (|req) begin
            take = 1'b1;
            nxt  = pick(sel_q + 2'd1, req);
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
            en_d    = 1'b0;
            cnt_d   = '0;
          end
        end else if (cnt_q == MAX_C &&
                     |(req & ~grant_q)) begin
          // Owner is still the last candidate in
          // the scan, so another source wins.
          take = 1'b1;
          nxt  = pick(sel_q + 2'd1, req);
        end else if (cnt_q != MAX_C) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (take) begin
      state_d = GRANT;
      grant_d = 4'b0001 << nxt;
      sel_d   = nxt;
      last_d  = nxt;
      cnt_d   = CNT_W'(1);
      en_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign en    = en_q;
  assign busy  = (state_q == GRANT);

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Scoreboard bench for mux_4to1_rr_arbiter.
// Directed vectors, expected values queued by driver.
module tb_mux_4to1_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       en;
  logic       busy;

  logic [3:0] d;
  logic       z1;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic       e;
  } exp_t;

  exp_t exp_q[$];

  mux_4to1_rr_arbiter #(
    .MAX_HOLD(8),
    .CNT_W(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .grant(grant),
    .sel  (sel),
    .en   (en),
    .busy (busy)
  );

  // behavioural mux_4to1 fed by the arbiter
  assign z1 = en ? d[sel] : 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic step(
    input logic [3:0] r,
    input logic [3:0] g,
    input logic [1:0] s
  );
    exp_t e;
    @(negedge clk);
    req = r;
    e.g = g;
    e.s = s;
    e.e = (g != 4'b0000);
    exp_q.push_back(e);
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_sel"},   32'(sel),   32'h0);
    chk({tag, "_en"},    32'(en),    32'h0);
    chk({tag, "_busy"},  32'(busy),  32'h0);
  endtask

  // monitor: pop one expectation per edge
  always @(posedge clk) begin
    exp_t e;
    logic ez;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ez = e.e ? d[e.s] : 1'b0;
      chk("grant", 32'(grant), 32'(e.g));
      chk("sel",   32'(sel),   32'(e.s));
      chk("en",    32'(en),    32'(e.e));
      chk("busy",  32'(busy),  32'(e.e));
      chk("z1",    32'(z1),    32'(ez));
    end
  end

  // invariants every cycle
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1) begin
      chk("onehot0", 32'($onehot0(grant)), 32'h1);
      if (grant != 4'b0000)
        chk("sel_idx", 32'(grant),
            32'(4'b0001 << sel));
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    d       = 4'b1010;
    req     = 4'b1111;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    chk_clear("rst");

    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 4'b0001, 2'd0);

    // rotation, owner drops each cycle
    step(4'b1110, 4'b0010, 2'd1);
    step(4'b1101, 4'b0100, 2'd2);
    step(4'b1011, 4'b1000, 2'd3);
    step(4'b0111, 4'b0001, 2'd0);
    step(4'b0000, 4'b0000, 2'd0);

    // hold limit
    step(4'b0001, 4'b0001, 2'd0);
    for (int i = 0; i < 7; i++)
      step(4'b0101, 4'b0001, 2'd0);
    step(4'b0101, 4'b0100, 2'd2);

    // idle keeps sel, then scan from 3
    step(4'b0000, 4'b0000, 2'd2);
    step(4'b1001, 4'b1000, 2'd3);

    // lone owner never loses grant
    step(4'b0001, 4'b0001, 2'd0);
    for (int i = 0; i < 20; i++)
      step(4'b0001, 4'b0001, 2'd0);
    step(4'b0000, 4'b0000, 2'd0);

    // async reset mid-grant
    step(4'b0100, 4'b0100, 2'd2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    chk_clear("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0100, 4'b0100, 2'd2);

    // mux integration: z1 follows d[1]
    step(4'b0010, 4'b0010, 2'd1);
    step(4'b0010, 4'b0010, 2'd1);
    step(4'b0000, 4'b0000, 2'd1);

    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #3;
    chk("drain", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
